tt_freq_lock_detect: RTL and testbench
======================================

// Module: tt_freq_lock_detect
// PURPOSE
//   Downstream consumer of the divided 10 MHz feedback clock. Samples i_fb_clk in the 30 MHz i_clk domain.
//   Counts feedback rising edges over a fixed window of i_clk cycles and compares each count with the expected value.
//   Drives a lock indicator with acquire/release hysteresis for the clock-generation control logic and for debug.
// PARAMETERS
//   WIN_CYCLES     300  i_clk cycles per measurement window (>=4)
//   EXPECTED       100  nominal feedback edges per window
//   TOL            2    accepted +/- deviation from EXPECTED (TOL <= EXPECTED)
//   LOCK_WINDOWS   4    consecutive good windows needed to assert lock (>=1)
//   UNLOCK_WINDOWS 2    consecutive bad windows needed to drop lock (>=1)
//   CNT_W          $clog2(WIN_CYCLES+1)  width of edge/window counters (derived)
// PORTS
//   i_clk          in   1      30 MHz clock; single clock domain
//   i_rst_n        in   1      asynchronous active-low reset
//   i_en           in   1      measurement enable; low = idle/clear
//   i_fb_clk       in   1      divided feedback clock, asynchronous to sampling; synchronised internally
//   o_lock         out  1      frequency lock indicator (registered)
//   o_count_valid  out  1      one-cycle pulse: o_edge_count updated
//   o_edge_count   out  CNT_W  edge count of last completed window
//   o_stuck        out  1      last completed window counted zero edges
//   o_state        out  2      FSM state: 0 UNLOCKED, 1 ACQUIRE, 2 LOCKED, 3 HOLD
// BEHAVIOUR
//   Reset: all outputs 0, FSM UNLOCKED, all counters and synchroniser flops 0.
//   Input path: 2-flop synchroniser on i_fb_clk, then a delay flop.
//     A rise is detected when the sync output is 1 and the delay flop is 0: a 1-cycle edge strobe, 3 i_clk after the pin rises.
//   Window counter: counts 0..WIN_CYCLES-1 while i_en=1, then wraps to 0.
//   Edge counter: increments on each strobe and saturates at 2^CNT_W-1.
//     A strobe in the last window cycle (win_cnt==WIN_CYCLES-1) counts in the closing window.
//     The edge counter restarts at 0 on the next cycle.
//   Window end (win_cnt==WIN_CYCLES-1): next cycle loads o_edge_count with the final count, pulses o_count_valid,
//     sets o_stuck=(count==0), and applies the FSM transition.
//   good = (count >= EXPECTED-TOL) && (count <= EXPECTED+TOL); unsigned compare; bounds computed at elaboration.
//   FSM transitions, evaluated only at window end; good_cnt and bad_cnt are internal counters:
//     UNLOCKED: good -> ACQUIRE with good_cnt=1, or -> LOCKED if LOCK_WINDOWS==1; bad -> stay.
//     ACQUIRE : good -> good_cnt+1, and -> LOCKED when good_cnt reaches LOCK_WINDOWS; bad -> UNLOCKED with good_cnt=0.
//     LOCKED  : good -> stay; bad -> HOLD with bad_cnt=1, or -> UNLOCKED if UNLOCK_WINDOWS==1.
//     HOLD    : good -> LOCKED with bad_cnt=0; bad -> bad_cnt+1, and -> UNLOCKED when bad_cnt reaches UNLOCK_WINDOWS.
//   o_lock = 1 in LOCKED or HOLD. It is registered and changes in the same cycle as o_count_valid.
//   i_en=0: synchronously clears the window/edge counters, good_cnt/bad_cnt, o_count_valid and o_lock; FSM -> UNLOCKED.
//     o_edge_count and o_stuck hold their last values.
//     A partial window aborted by i_en falling is never evaluated.
//     After i_en rises, the first window starts at win_cnt=0 on that cycle.
//   Async reset mid-window: immediate clear. The first post-reset window is treated as a normal window.
//   The 3-cycle synchroniser latency shifts edges across window boundaries; steady-state count is unaffected.
//     The first window after enable may read EXPECTED-1.
// TESTING (WIN=300, EXP=100, TOL=2, LOCK=4, UNLOCK=2)
//   fb = i_clk/3, 50% duty, en=1 from reset -> count 99..100 each window; o_state 0->1->1->1->2;
//     o_lock=1 at the 4th o_count_valid (~cycle 1201).
//   fb = i_clk/4 -> o_edge_count=75 every window; o_lock stays 0; o_state stays 0.
//   Bench-driven edges: 98 and 102 per window are accepted as good; 97 and 103 are bad.
//     3 good windows then 1 bad -> state 1->0; lock then needs 4 fresh good windows.
//   LOCKED, fb held low for one window -> o_stuck=1, count 0, state 3, o_lock stays 1;
//     next good window -> state 2.
//   LOCKED, then 2 bad windows (fb = i_clk/6, 50 edges) -> o_lock falls in the cycle of the 2nd o_count_valid; state 0.
//   i_en low at win_cnt=150 -> o_lock=0 and state 0 next cycle; no o_count_valid pulse for the partial window.
//     i_rst_n low mid-window -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/tt_freq_lock_detect.sv
// tt_freq_lock_detect
//   Measures the divided feedback clock against the local sampling clock. Feedback rising
//   edges are counted over fixed windows of i_clk cycles, each window count is compared with
//   EXPECTED +/- TOL, and a lock indicator with acquire/release hysteresis is maintained.
// Ports
//   i_clk         sampling clock (single clock domain)
//   i_rst_n       asynchronous active-low reset
//   i_en          measurement enable; low idles and clears the measurement
//   i_fb_clk      feedback clock, asynchronous, synchronised internally
//   o_lock        registered lock indicator (LOCKED or HOLD)
//   o_count_valid one-cycle pulse when o_edge_count is updated
//   o_edge_count  edge count of the last completed window
//   o_stuck       last completed window counted zero edges
//   o_state       0 UNLOCKED, 1 ACQUIRE, 2 LOCKED, 3 HOLD
module tt_freq_lock_detect #(
  parameter int unsigned WIN_CYCLES     = 300,
  parameter int unsigned EXPECTED       = 100,
  parameter int unsigned TOL            = 2,
  parameter int unsigned LOCK_WINDOWS   = 4,
  parameter int unsigned UNLOCK_WINDOWS = 2,
  parameter int unsigned CNT_W          = $clog2(WIN_CYCLES + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_fb_clk,
  output logic             o_lock,
  output logic             o_count_valid,
  output logic [CNT_W-1:0] o_edge_count,
  output logic             o_stuck,
  output logic [1:0]       o_state
);

  localparam int unsigned GoodW = $clog2(LOCK_WINDOWS + 1);
  localparam int unsigned BadW  = $clog2(UNLOCK_WINDOWS + 1);
  localparam logic [CNT_W-1:0] WinLast = CNT_W'(WIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam int unsigned LoBound = EXPECTED - TOL;
  localparam int unsigned HiBound = EXPECTED + TOL;
  localparam logic [GoodW-1:0] GoodTarget = GoodW'(LOCK_WINDOWS);
  localparam logic [BadW-1:0]  BadTarget  = BadW'(UNLOCK_WINDOWS);

  typedef enum logic [1:0] {
    StUnlocked = 2'd0,
    StAcquire  = 2'd1,
    StLocked   = 2'd2,
    StHold     = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             fb_sync1_q, fb_sync2_q, fb_dly_q;
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] edge_count_q, edge_count_d;
  logic [GoodW-1:0] good_cnt_q, good_cnt_d;
  logic [BadW-1:0]  bad_cnt_q, bad_cnt_d;
  logic             valid_q, valid_d;
  logic             stuck_q, stuck_d;
  logic             lock_q, lock_d;

  logic             strobe, win_end, good;
  logic [CNT_W-1:0] fin_cnt;
  logic [GoodW-1:0] good_inc;
  logic [BadW-1:0]  bad_inc;

  always_comb begin
    strobe   = fb_sync2_q & ~fb_dly_q;
    win_end  = (win_cnt_q == WinLast);
    // A strobe in the closing cycle still belongs to the closing window.
    fin_cnt  = (strobe && (edge_cnt_q != CntMax)) ? edge_cnt_q + 1'b1 : edge_cnt_q;
    good     = (32'(fin_cnt) >= LoBound) && (32'(fin_cnt) <= HiBound);
    good_inc = good_cnt_q + 1'b1;
    bad_inc  = bad_cnt_q + 1'b1;

    state_d      = state_q;
    win_cnt_d    = win_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    edge_count_d = edge_count_q;
    good_cnt_d   = good_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    valid_d      = 1'b0;
    stuck_d      = stuck_q;
    lock_d       = lock_q;

    if (!i_en) begin
      // Idle: partial window discarded; last reported count and stuck flag are kept.
      state_d    = StUnlocked;
      win_cnt_d  = '0;
      edge_cnt_d = '0;
      good_cnt_d = '0;
      bad_cnt_d  = '0;
      lock_d     = 1'b0;
    end else begin
      win_cnt_d  = win_end ? '0 : win_cnt_q + 1'b1;
      edge_cnt_d = win_end ? '0 : fin_cnt;
      if (win_end) begin
        valid_d      = 1'b1;
        edge_count_d = fin_cnt;
        stuck_d      = (fin_cnt == '0);
        unique case (state_q)
          StUnlocked: begin
            if (good) begin
              if (LOCK_WINDOWS == 1) begin
                state_d    = StLocked;
                good_cnt_d = '0;
              end else begin
                state_d    = StAcquire;
                good_cnt_d = GoodW'(1);
              end
            end
          end
          StAcquire: begin
            if (good) begin
              if (good_inc == GoodTarget) begin
                state_d    = StLocked;
                good_cnt_d = '0;
              end else begin
                good_cnt_d = good_inc;
              end
            end else begin
              state_d    = StUnlocked;
              good_cnt_d = '0;
            end
          end
          StLocked: begin
            if (!good) begin
              if (UNLOCK_WINDOWS == 1) begin
                state_d   = StUnlocked;
                bad_cnt_d = '0;
              end else begin
                state_d   = StHold;
                bad_cnt_d = BadW'(1);
              end
            end
          end
          StHold: begin
            if (good) begin
              state_d   = StLocked;
              bad_cnt_d = '0;
            end else if (bad_inc == BadTarget) begin
              state_d   = StUnlocked;
              bad_cnt_d = '0;
            end else begin
              bad_cnt_d = bad_inc;
            end
          end
          default: state_d = StUnlocked;
        endcase
        lock_d = (state_d == StLocked) || (state_d == StHold);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StUnlocked;
      fb_sync1_q   <= 1'b0;
      fb_sync2_q   <= 1'b0;
      fb_dly_q     <= 1'b0;
      win_cnt_q    <= '0;
      edge_cnt_q   <= '0;
      edge_count_q <= '0;
      good_cnt_q   <= '0;
      bad_cnt_q    <= '0;
      valid_q      <= 1'b0;
      stuck_q      <= 1'b0;
      lock_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fb_sync1_q   <= i_fb_clk;
      fb_sync2_q   <= fb_sync1_q;
      fb_dly_q     <= fb_sync2_q;
      win_cnt_q    <= win_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      edge_count_q <= edge_count_d;
      good_cnt_q   <= good_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      valid_q      <= valid_d;
      stuck_q      <= stuck_d;
      lock_q       <= lock_d;
    end
  end

  assign o_lock        = lock_q;
  assign o_count_valid = valid_q;
  assign o_edge_count  = edge_count_q;
  assign o_stuck       = stuck_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_tt_freq_lock_detect.sv
// Testbench for tt_freq_lock_detect: feedback waveforms are built per window, a reference
// model derives the expected window counts and lock states, and a monitor compares them
// against each o_count_valid pulse.
module tb_tt_freq_lock_detect;

  localparam int WIN    = 300;
  localparam int EXP    = 100;
  localparam int TOL    = 2;
  localparam int LOCK   = 4;
  localparam int UNLOCK = 2;
  localparam int CNT_W  = $clog2(WIN + 1);
  // Pin-to-count delay: a rise driven in cycle t lands in window cycle t+2.
  localparam int LAT    = 2;

  typedef struct {
    int count;
    bit stuck;
    int state;
    bit lock;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             fb = 1'b0;
  logic             o_lock, o_count_valid, o_stuck;
  logic [CNT_W-1:0] o_edge_count;
  logic [1:0]       o_state;

  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  bit   fb_arr[$];

  tt_freq_lock_detect #(
    .WIN_CYCLES    (WIN),
    .EXPECTED      (EXP),
    .TOL           (TOL),
    .LOCK_WINDOWS  (LOCK),
    .UNLOCK_WINDOWS(UNLOCK)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en         (en),
    .i_fb_clk     (fb),
    .o_lock       (o_lock),
    .o_count_valid(o_count_valid),
    .o_edge_count (o_edge_count),
    .o_stuck      (o_stuck),
    .o_state      (o_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic gen_period(input int p, input int len);
    for (int i = 0; i < len; i++) fb_arr.push_back(bit'((fb_arr.size() % p) < (p / 2)));
  endtask

  task automatic gen_nedges(input int n);
    bit w[WIN];
    for (int i = 0; i < WIN; i++) w[i] = 1'b0;
    for (int k = 0; k < n; k++) w[(k * WIN) / n] = 1'b1;
    for (int i = 0; i < WIN; i++) fb_arr.push_back(w[i]);
  endtask

  task automatic gen_low();
    for (int i = 0; i < WIN; i++) fb_arr.push_back(1'b0);
  endtask

  // Counts rising edges of the planned waveform per window and applies the lock rules as
  // streaks: lock after LOCK consecutive good windows, release after UNLOCK consecutive bad.
  task automatic model_push(input int nwin);
    int cnt[$];
    bit prev, locked, good;
    int gs, bs, st, c;
    exp_t e;
    for (int w = 0; w < nwin; w++) cnt.push_back(0);
    prev = 1'b0;
    for (int t = 0; t < fb_arr.size(); t++) begin
      if (fb_arr[t] && !prev && ((t + LAT) / WIN) < nwin) cnt[(t + LAT) / WIN]++;
      prev = fb_arr[t];
    end
    locked = 1'b0;
    gs = 0;
    bs = 0;
    for (int w = 0; w < nwin; w++) begin
      c = (cnt[w] > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : cnt[w];
      good = (c >= EXP - TOL) && (c <= EXP + TOL);
      if (good) begin
        gs++;
        bs = 0;
        if (!locked && gs >= LOCK) begin
          locked = 1'b1;
          gs = 0;
        end
      end else begin
        bs++;
        gs = 0;
        if (locked && bs >= UNLOCK) begin
          locked = 1'b0;
          bs = 0;
        end
      end
      st = locked ? ((bs > 0) ? 3 : 2) : ((gs > 0) ? 1 : 0);
      e.count = c;
      e.stuck = (c == 0);
      e.state = st;
      e.lock  = locked;
      sb_q.push_back(e);
    end
  endtask

  // Plays fb_arr with en high for nwin windows plus extra cycles, then ends the segment either
  // by dropping en or by an asynchronous reset.
  task automatic run_segment(input int nwin, input int extra, input bit rst_abort);
    model_push(nwin);
    for (int t = 0; t < nwin * WIN + extra; t++) begin
      @(posedge clk);
      #1;
      en = 1'b1;
      fb = fb_arr[t];
    end
    if (rst_abort) begin
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_async_lock", o_lock, 0);
      chk("rst_async_valid", o_count_valid, 0);
      chk("rst_async_count", o_edge_count, 0);
      chk("rst_async_stuck", o_stuck, 0);
      chk("rst_async_state", o_state, 0);
      en = 1'b0;
      fb = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
    end else begin
      @(posedge clk);
      #1;
      en = 1'b0;
      fb = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("en_off_lock", o_lock, 0);
      chk("en_off_state", o_state, 0);
    end
    repeat (4) @(posedge clk);
    chk("scoreboard_drained", sb_q.size(), 0);
    sb_q.delete();
    fb_arr.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n && o_count_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=pulse expected=none at %0t", $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("edge_count", o_edge_count, mon_e.count);
        chk("stuck", o_stuck, mon_e.stuck);
        chk("state", o_state, mon_e.state);
        chk("lock", o_lock, mon_e.lock);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int kind;
    #23;
    chk("reset_lock", o_lock, 0);
    chk("reset_valid", o_count_valid, 0);
    chk("reset_count", o_edge_count, 0);
    chk("reset_stuck", o_stuck, 0);
    chk("reset_state", o_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Nominal divide-by-3 feedback: acquire then lock on the 4th window.
    gen_period(3, 6 * WIN);
    run_segment(6, 0, 1'b0);

    // Divide-by-4 feedback: 75 per window, never locks.
    gen_period(4, 3 * WIN);
    run_segment(3, 0, 1'b0);

    // Tolerance edges, aborted acquire, stuck window in LOCKED, release via two bad windows.
    gen_nedges(98);
    gen_nedges(102);
    gen_nedges(100);
    gen_nedges(97);
    gen_nedges(100);
    gen_nedges(102);
    gen_nedges(98);
    gen_nedges(100);
    gen_low();
    gen_nedges(100);
    gen_period(6, 2 * WIN);
    gen_nedges(103);
    run_segment(13, 0, 1'b0);

    // Lock, then drop enable mid-window: the partial window must not report.
    gen_period(3, 5 * WIN + 150);
    run_segment(5, 150, 1'b0);

    // Lock, then asynchronous reset mid-window; the next run starts normally.
    gen_period(3, 4 * WIN + 150);
    run_segment(4, 150, 1'b1);
    gen_period(3, 2 * WIN);
    run_segment(2, 0, 1'b0);

    // Randomized mix of window types.
    for (int w = 0; w < 16; w++) begin
      kind = int'($urandom_range(0, 9));
      if (kind <= 4) gen_nedges(EXP - 4 + int'($urandom_range(0, 8)));
      else if (kind <= 6) gen_period(3, WIN);
      else if (kind == 7) gen_period(4, WIN);
      else if (kind == 8) gen_low();
      else gen_period(6, WIN);
    end
    run_segment(16, int'($urandom_range(0, 200)), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
